// File: rtl/myproject_mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate unit.
//   - default operand/result/accumulator widths and pipeline depth
//   - sat_signed(): clip a signed value to a narrower signed range, with flag
//   - params_legal(): parameter-combination check used by the top level
package myproject_mac_pkg;

  localparam int unsigned DEF_DIN0_WIDTH = 11;
  localparam int unsigned DEF_DIN1_WIDTH = 18;
  localparam int unsigned DEF_DOUT_WIDTH = 29;
  localparam int unsigned DEF_ACC_WIDTH  = 36;
  localparam int unsigned DEF_NUM_STAGE  = 3;

  // Working width of the saturation helper; accumulators must be narrower.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_result_t;

  // value holds a from_w-bit signed quantity in its low bits; the result is
  // that quantity clipped to [-2^(to_w-1), 2^(to_w-1)-1].
  function automatic sat_result_t sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             from_w,
    input int unsigned             to_w
  );
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_result_t             r;
    v  = (value <<< (SAT_W - from_w)) >>> (SAT_W - from_w);
    hi = (64'sd1 <<< (to_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (to_w - 1));
    if (v > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end else begin
      r.value = v;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

  function automatic bit params_legal(
    input int unsigned din0_w,
    input int unsigned din1_w,
    input int unsigned dout_w,
    input int unsigned acc_w,
    input int unsigned num_stage
  );
    return (num_stage >= 1) && (dout_w >= 2) && (dout_w <= acc_w) &&
           (acc_w >= din0_w + din1_w) && (acc_w < SAT_W);
  endfunction

endpackage

// File: rtl/myproject_mac_pipe_if.sv
// Beat/result bus of the MAC unit.
//   master: drives in_valid, din0, din1, acc_first, acc_last;
//           receives out_valid, dout, dout_sat
//   slave : the MAC itself (mirror directions)
interface myproject_mac_pipe_if
  import myproject_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH
) ();

  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  acc_first;
  logic                  acc_last;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  dout_sat;

  modport master (
    output in_valid, din0, din1, acc_first, acc_last,
    input  out_valid, dout, dout_sat
  );

  modport slave (
    input  in_valid, din0, din1, acc_first, acc_last,
    output out_valid, dout, dout_sat
  );

endinterface

// File: rtl/myproject_mac_mul_pipe.sv
// Signed NUM_STAGE-deep multiplier with matching valid/first/last shift
// register; all stages hold when i_ce=0. Maps onto DSP48 input/M/P registers.
//   i_clk, i_rst, i_ce           : clock, sync active-high reset, clock enable
//   i_valid, i_a, i_b            : operand beat
//   i_first, i_last              : frame sideband, ignored when i_valid=0
//   o_prod, o_valid, o_first, o_last : product and sideband NUM_STAGE later
module myproject_mac_mul_pipe
  import myproject_mac_pkg::*;
#(
  parameter  int unsigned A_WIDTH   = DEF_DIN0_WIDTH,
  parameter  int unsigned B_WIDTH   = DEF_DIN1_WIDTH,
  parameter  int unsigned NUM_STAGE = DEF_NUM_STAGE,
  localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ce,
  input  logic                      i_valid,
  input  logic signed [A_WIDTH-1:0] i_a,
  input  logic signed [B_WIDTH-1:0] i_b,
  input  logic                      i_first,
  input  logic                      i_last,
  output logic signed [P_WIDTH-1:0] o_prod,
  output logic                      o_valid,
  output logic                      o_first,
  output logic                      o_last
);

  logic signed [P_WIDTH-1:0] w_prod;
  logic signed [P_WIDTH-1:0] r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]      r_valid;
  logic [NUM_STAGE-1:0]      r_first;
  logic [NUM_STAGE-1:0]      r_last;

  assign w_prod = i_a * i_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_first <= '0;
      r_last  <= '0;
      for (int unsigned i = 0; i < NUM_STAGE; i++) r_prod[i] <= '0;
    end else if (i_ce) begin
      r_prod[0]  <= w_prod;
      r_valid[0] <= i_valid;
      r_first[0] <= i_valid & i_first;
      r_last[0]  <= i_valid & i_last;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        r_prod[i]  <= r_prod[i-1];
        r_valid[i] <= r_valid[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_prod  = r_prod[NUM_STAGE-1];
  assign o_valid = r_valid[NUM_STAGE-1];
  assign o_first = r_first[NUM_STAGE-1];
  assign o_last  = r_last[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate with frame delimiting and saturated
// output. Latency from an acc_last beat to out_valid is NUM_STAGE+1 enabled
// cycles; one beat per enabled cycle, no backpressure.
//   ap_clk, ap_rst : clock, synchronous active-high reset (overrides ce)
//   ce             : clock enable; 0 freezes every register incl. outputs
//   bus (slave)    : in_valid/din0/din1/acc_first/acc_last in,
//                    out_valid/dout/dout_sat out
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned NUM_STAGE  = DEF_NUM_STAGE
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ce,
  myproject_mac_pipe_if.slave bus
);

  localparam int unsigned P_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  if (!params_legal(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, ACC_WIDTH, NUM_STAGE))
  begin : g_param_check
    $error("myproject_mac_pipe: illegal width/stage parameter combination");
  end

  logic signed [P_WIDTH-1:0]   w_prod;
  logic                        w_valid;
  logic                        w_first;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_prod_sext;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  sat_result_t                 w_sat;
  logic                        w_unused_sat_hi;

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_out_valid;
  logic [DOUT_WIDTH-1:0]        r_dout;
  logic                         r_dout_sat;

  myproject_mac_mul_pipe #(
    .A_WIDTH   (DIN0_WIDTH),
    .B_WIDTH   (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_ce    (ce),
    .i_valid (bus.in_valid),
    .i_a     ($signed(bus.din0)),
    .i_b     ($signed(bus.din1)),
    .i_first (bus.acc_first),
    .i_last  (bus.acc_last),
    .o_prod  (w_prod),
    .o_valid (w_valid),
    .o_first (w_first),
    .o_last  (w_last)
  );

  assign w_prod_sext = ACC_WIDTH'(w_prod);
  assign w_acc_next  = w_first ? w_prod_sext : r_acc + w_prod_sext;
  assign w_sat       = sat_signed(SAT_W'(w_acc_next), ACC_WIDTH, DOUT_WIDTH);
  // Clipped value fits DOUT_WIDTH, so the upper bits are pure sign copies.
  assign w_unused_sat_hi = ^w_sat.value[SAT_W-1:DOUT_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_dout_sat  <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_valid & w_last;
      if (w_valid) r_acc <= w_acc_next;
      if (w_valid & w_last) begin
        r_dout     <= w_sat.value[DOUT_WIDTH-1:0];
        r_dout_sat <= w_sat.sat;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.dout_sat  = r_dout_sat;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
module tb_myproject_mac_pipe;

  localparam int unsigned NS = 3;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ce     = 1'b0;

  always #5 ap_clk = ~ap_clk;

  myproject_mac_pipe_if #(
    .DIN0_WIDTH (11),
    .DIN1_WIDTH (18),
    .DOUT_WIDTH (29)
  ) bus ();

  myproject_mac_pipe #(
    .DIN0_WIDTH (11),
    .DIN1_WIDTH (18),
    .DOUT_WIDTH (29),
    .ACC_WIDTH  (36),
    .NUM_STAGE  (NS)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ce     (ce),
    .bus    (bus)
  );

  typedef struct {
    int d;
    bit s;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each enabled edge that leaves out_valid high is one result.
  bit   mon_en;
  exp_t mon_e;
  always @(posedge ap_clk) begin
    mon_en = (ce === 1'b1) && (ap_rst === 1'b0);
    if (mon_en) en_cnt++;
    #1;
    if (mon_en && bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid with nothing expected, dout=%0d", $signed(bus.dout));
      end else begin
        mon_e = q.pop_front();
        check_int("dout", int'($signed(bus.dout)), mon_e.d);
        check_int("dout_sat", int'(bus.dout_sat), int'(mon_e.s));
        check_int("latency_cycle", en_cnt, mon_e.cyc);
      end
    end
  end

  task automatic beat(input int a, input int b, input bit f, input bit l,
                      input bit push, input int ed, input bit es);
    @(negedge ap_clk);
    ce            = 1'b1;
    bus.in_valid  = 1'b1;
    bus.din0      = 11'(a);
    bus.din1      = 18'(b);
    bus.acc_first = f;
    bus.acc_last  = l;
    if (push) q.push_back('{ed, es, en_cnt + 1 + int'(NS)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ap_clk);
      ce            = 1'b1;
      bus.in_valid  = 1'b0;
      bus.acc_first = 1'b0;
      bus.acc_last  = 1'b0;
    end
  endtask

  // Reset is applied with ce=0 to show it does not depend on ce.
  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst       = 1'b1;
    ce           = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ce     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.acc_first = 1'b0;
    bus.acc_last  = 1'b0;

    do_reset();
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_dout", int'($signed(bus.dout)), 0);
    check_int("rst_dout_sat", int'(bus.dout_sat), 0);

    // Single-product frame.
    beat(3, -5, 1, 1, 1, -15, 0);
    idle(6);

    // 4-beat frame: 20 - 21 - 100 + 1.
    beat(2, 10, 1, 0, 0, 0, 0);
    beat(-3, 7, 0, 0, 0, 0, 0);
    beat(100, -1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 1, 1, -100, 0);
    idle(6);

    // Positive saturation: 4 * 2^27 = 2^29.
    beat(-1024, -131072, 1, 0, 0, 0, 0);
    beat(-1024, -131072, 0, 0, 0, 0, 0);
    beat(-1024, -131072, 0, 0, 0, 0, 0);
    beat(-1024, -131072, 0, 1, 1, 268435455, 1);
    idle(6);

    // Negative saturation: +131072 is not an 18-bit value, so use 131071.
    beat(-1024, 131071, 1, 0, 0, 0, 0);
    beat(-1024, 131071, 0, 0, 0, 0, 0);
    beat(-1024, 131071, 0, 0, 0, 0, 0);
    beat(-1024, 131071, 0, 1, 1, -268435456, 1);
    idle(6);

    // ce gap mid-pipe with junk inputs that must not be sampled, then a bubble.
    beat(5, 5, 1, 0, 0, 0, 0);
    @(negedge ap_clk);
    ce            = 1'b0;
    bus.in_valid  = 1'b1;
    bus.din0      = 11'(-1);
    bus.din1      = 18'(100);
    bus.acc_first = 1'b1;
    bus.acc_last  = 1'b1;
    repeat (2) @(negedge ap_clk);
    idle(1);
    beat(6, 6, 0, 1, 1, 61, 0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      ce            = 1'b1;
      bus.in_valid  = 1'b0;
      bus.acc_first = 1'b0;
      bus.acc_last  = 1'b0;
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_int("ce_gap_out_seen", int'(found), 1);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_int("ce0_hold_valid", int'(bus.out_valid), 1);
      check_int("ce0_hold_dout", int'($signed(bus.dout)), 61);
    end
    idle(6);

    // Back-to-back frames: 14, then single -56, then 34.
    beat(1, 2, 1, 0, 0, 0, 0);
    beat(3, 4, 0, 1, 1, 14, 0);
    beat(-7, 8, 1, 1, 1, -56, 0);
    beat(5, 6, 1, 0, 0, 0, 0);
    beat(2, 2, 0, 1, 1, 34, 0);
    idle(8);

    // Reset with two beats in flight: nothing may come out for them.
    beat(9, 9, 1, 0, 0, 0, 0);
    beat(8, 8, 0, 1, 0, 0, 0);
    do_reset();
    check_int("midrst_out_valid", int'(bus.out_valid), 0);
    check_int("midrst_dout", int'($signed(bus.dout)), 0);
    idle(6);
    beat(7, 7, 1, 1, 1, 49, 0);
    // last without first accumulates onto the held acc: 49 + 6.
    beat(2, 3, 0, 1, 1, 55, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    check_int("scoreboard_drained", q.size(), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
